// File: rtl/spdif_dma_pkg.sv
// Shared definitions for the SPDIF/DMA buffer family (Rx buffer, Tx buffer,
// DMA controller): default bus widths, half index type, drop counter width.
package spdif_dma_pkg;

    localparam int DMA_DWIDTH_DEF = 64;
    localparam int DMA_AWIDTH_DEF = 12;
    localparam int DROP_CNT_W     = 16;

    // Selects one of the two ping-pong halves.
    typedef logic half_idx_t;

endpackage

// File: rtl/spdif_rx_dma_buffer_if.sv
// Producer stream plus DMA device-0 responder bus of the Rx ping-pong buffer.
// master: producer/DMA side that drives requests; slave: the buffer.
interface spdif_rx_dma_buffer_if
    import spdif_dma_pkg::*;
#(
    parameter int DW = DMA_DWIDTH_DEF,
    parameter int AW = DMA_AWIDTH_DEF
);
    logic          s_valid_i;
    logic [DW-1:0] s_data_i;
    logic          s_ready_o;
    logic          dma_en_i;
    logic          dma_we_i;
    logic [AW-1:0] dma_adr_i;
    logic [DW-1:0] dma_dat_i;
    logic [DW-1:0] dma_dat_o;

    modport master (
        output s_valid_i, s_data_i, dma_en_i, dma_we_i, dma_adr_i, dma_dat_i,
        input  s_ready_o, dma_dat_o
    );

    modport slave (
        input  s_valid_i, s_data_i, dma_en_i, dma_we_i, dma_adr_i, dma_dat_i,
        output s_ready_o, dma_dat_o
    );
endinterface

// File: rtl/spdif_rx_dma_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module sdp_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; commits at the edge where we is high.
    // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; same-edge writes are not yet visible, giving read-first behaviour.
    // NOTE: non-blocking assignment on sequential state keeps read-first ordering race-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/spdif_rx_dma_buffer.sv
// Ping-pong sample buffer between the SPDIF receiver and DMA device-0 bus.
// The producer fills one half while the DMA drains the other; rel_i hands a
// drained half back. Words arriving at a full half are dropped and counted.
module spdif_rx_dma_buffer
    import spdif_dma_pkg::*;
#(
    parameter int DMA_DWIDTH = DMA_DWIDTH_DEF,
    parameter int DMA_AWIDTH = DMA_AWIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    spdif_rx_dma_buffer_if.slave  bus,
    input  logic                  rel_i,
    input  logic                  clr_i,
    output logic                  half_done_o,
    output half_idx_t             half_idx_o,
    output logic [1:0]            full_o,
    output logic                  overrun_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);
    logic [DMA_AWIDTH-1:0] wp;
    logic [1:0]            full, full_next;
    half_idx_t             rd_half, cur_half;
    logic                  last_in_half, s_ready, accept, drop, rel_ok, completes;

    logic                  ram_we;
    logic [DMA_AWIDTH-1:0] ram_waddr;
    logic [DMA_DWIDTH-1:0] ram_wdata;

    assign cur_half     = wp[DMA_AWIDTH-1];
    assign last_in_half = &wp[DMA_AWIDTH-2:0];

    // A DMA write owns the single RAM write port, so the producer stalls that cycle.
    assign s_ready      = ~full[cur_half] & ~bus.dma_we_i;
    assign bus.s_ready_o = s_ready;

    assign accept    = bus.s_valid_i & s_ready;
    assign completes = accept & last_in_half;
    assign drop      = bus.s_valid_i & full[cur_half];
    assign rel_ok    = rel_i & full[rd_half];
    assign full_o    = full;

    // Next full flags; release and completion always target different halves.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        full_next = full;
        if (rel_ok)    full_next[rd_half]  = 1'b0;
        if (completes) full_next[cur_half] = 1'b1;
    end

    // Write pointer, half flags, release order and half-complete pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp          <= '0;
            full        <= 2'b00;
            rd_half     <= 1'b0;
            half_done_o <= 1'b0;
            half_idx_o  <= 1'b0;
        end else begin
            full        <= full_next;
            half_done_o <= completes;
            if (accept)    wp         <= wp + 1'b1;
            if (completes) half_idx_o <= cur_half;
            if (rel_ok)    rd_half    <= ~rd_half;
        end
    end

    // Sticky overrun flag and saturating drop counter; clear beats a same-cycle drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_o  <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clr_i) begin
            overrun_o  <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overrun_o <= 1'b1;
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

    // Write-port mux: DMA writes take priority over producer words.
    always_comb begin
        ram_we    = bus.dma_we_i | accept;
        ram_waddr = wp;
        ram_wdata = bus.s_data_i;
        if (bus.dma_we_i) begin
            ram_waddr = bus.dma_adr_i;
            ram_wdata = bus.dma_dat_i;
        end
    end

    sdp_ram #(
        .WIDTH (DMA_DWIDTH),
        .DEPTH (2 ** DMA_AWIDTH)
    ) u_ram (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (bus.dma_en_i),
        .raddr (bus.dma_adr_i),
        .rdata (bus.dma_dat_o)
    );
endmodule

// File: tb/tb_spdif_rx_dma_buffer.sv
// Self-checking bench for spdif_rx_dma_buffer with a 16-word buffer (8-word halves).
// DMA read expectations are queued from a memory model when a read is issued
// and compared when the registered data appears.
module tb_spdif_rx_dma_buffer;
    localparam int DW = 64;
    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rel = 1'b0;
    logic        clr = 1'b0;
    logic        half_done;
    logic        half_idx;
    logic [1:0]  full;
    logic        overrun;
    logic [15:0] drop_cnt;

    spdif_rx_dma_buffer_if #(.DW(DW), .AW(AW)) bus ();

    spdif_rx_dma_buffer #(.DMA_DWIDTH(DW), .DMA_AWIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .rel_i       (rel),
        .clr_i       (clr),
        .half_done_o (half_done),
        .half_idx_o  (half_idx),
        .full_o      (full),
        .overrun_o   (overrun),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_m [16];
    int            wp_m;
    logic [DW-1:0] exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            pulse_cnt = 0;

    // Count half-complete pulses mid-cycle, away from both edges.
    always @(negedge clk) begin
        #2;
        if (half_done === 1'b1) pulse_cnt++;
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One producer attempt; model updated only if the DUT accepts.
    task automatic push(input logic [DW-1:0] d, output bit acc);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = d;
        #1;
        acc = bus.s_ready_o;
        if (acc) begin
            mem_m[wp_m] = d;
            wp_m = (wp_m + 1) % 16;
        end
        cycle();
        bus.s_valid_i = 1'b0;
    endtask

    // Issue a one-cycle DMA read and queue its expected data.
    task automatic dma_issue(input int addr);
        bus.dma_en_i  = 1'b1;
        bus.dma_adr_i = AW'(addr);
        exp_q.push_back(mem_m[addr]);
        cycle();
        bus.dma_en_i  = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] exp;
        bus.s_valid_i = 0; bus.s_data_i = '0; bus.dma_en_i = 0; bus.dma_we_i = 0;
        bus.dma_adr_i = '0; bus.dma_dat_i = '0;
        wp_m = 0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        exp = '0;
        n_cmp++;
        if ({half_done, half_idx, full, overrun, drop_cnt} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_state: got %b/%b/%b/%b/%h required all zero",
                     half_done, half_idx, full, overrun, drop_cnt);
        end
        n_cmp++;
        if (bus.dma_dat_o !== exp) begin
            n_err++; $display("FAIL reset_dma_dat: got %h required %h", bus.dma_dat_o, exp);
        end
        #1;
        n_cmp++;
        if (bus.s_ready_o !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b required 1", bus.s_ready_o);
        end
    endtask

    task automatic test_fill_half();
        bit acc;
        int n_acc = 0;
        int p0 = pulse_cnt;
        logic [DW-1:0] exp;
        for (int i = 0; i < 8; i++) begin
            push(64'h10 + 64'(i), acc);
            if (acc) n_acc++;
        end
        n_cmp++;
        if (n_acc !== 8) begin
            n_err++; $display("FAIL fill0_accepts: got %0d required 8", n_acc);
        end
        n_cmp++;
        if ({half_done, half_idx, full} !== 4'b1_0_01) begin
            n_err++; $display("FAIL fill0_done: got done=%b idx=%b full=%b required 1 0 01",
                              half_done, half_idx, full);
        end
        cycle();
        n_cmp++;
        if (half_done !== 1'b0 || (pulse_cnt - p0) !== 1) begin
            n_err++; $display("FAIL fill0_pulse_width: got done=%b pulses=%0d required 0 1",
                              half_done, pulse_cnt - p0);
        end
        for (int i = 0; i < 8; i++) begin
            dma_issue(i);
            exp = exp_q.pop_front();
            n_cmp++;
            if (bus.dma_dat_o !== exp) begin
                n_err++; $display("FAIL fill0_read[%0d]: got %h required %h", i, bus.dma_dat_o, exp);
            end
        end
        cycle();
        n_cmp++;
        if (bus.dma_dat_o !== 64'h17) begin
            n_err++; $display("FAIL read_hold: got %h required 17", bus.dma_dat_o);
        end
    endtask

    task automatic test_overrun();
        bit acc;
        bit ready_seen = 0;
        int n_acc = 0;
        logic [DW-1:0] exp;
        for (int i = 0; i < 8; i++) begin
            push(64'h18 + 64'(i), acc);
            if (acc) n_acc++;
        end
        n_cmp++;
        if (n_acc !== 8 || full !== 2'b11 || half_idx !== 1'b1) begin
            n_err++; $display("FAIL fill1: got acc=%0d full=%b idx=%b required 8 11 1",
                              n_acc, full, half_idx);
        end
        for (int i = 0; i < 3; i++) begin
            push(64'hEE0 + 64'(i), acc);
            if (acc) ready_seen = 1;
        end
        n_cmp++;
        if (ready_seen !== 1'b0 || overrun !== 1'b1 || drop_cnt !== 16'd3) begin
            n_err++; $display("FAIL overrun: got ready=%b ovr=%b drops=%0d required 0 1 3",
                              ready_seen, overrun, drop_cnt);
        end
        rel = 1'b1;
        cycle();
        rel = 1'b0;
        #1;
        n_cmp++;
        if (full !== 2'b10 || bus.s_ready_o !== 1'b1) begin
            n_err++; $display("FAIL release_resume: got full=%b ready=%b required 10 1",
                              full, bus.s_ready_o);
        end
        push(64'h55, acc);
        dma_issue(0);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.dma_dat_o !== exp || exp !== 64'h55) begin
            n_err++; $display("FAIL resume_addr0: got %h required 55", bus.dma_dat_o);
        end
    endtask

    task automatic test_dma_write_stall();
        bit acc;
        int n_low = 0;
        int n_acc = 0;
        int addrs [8] = '{1, 2, 3, 4, 5, 6, 12, 13};
        logic [DW-1:0] exp;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0 || drop_cnt !== 16'd0) begin
            n_err++; $display("FAIL clear: got ovr=%b drops=%0d required 0 0", overrun, drop_cnt);
        end
        for (int c = 0; c < 8; c++) begin
            bus.dma_we_i  = (c == 2 || c == 3);
            bus.dma_adr_i = AW'(10 + c);
            bus.dma_dat_i = 64'hD000 + 64'(c);
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 64'h100 + 64'(n_acc);
            #1;
            if (bus.s_ready_o !== 1'b1) n_low++;
            if (bus.dma_we_i) mem_m[10 + c] = bus.dma_dat_i;
            if (bus.s_ready_o === 1'b1) begin
                mem_m[wp_m] = bus.s_data_i;
                wp_m = (wp_m + 1) % 16;
                n_acc++;
            end
            cycle();
        end
        bus.s_valid_i = 1'b0;
        bus.dma_we_i  = 1'b0;
        n_cmp++;
        if (n_low !== 2 || drop_cnt !== 16'd0 || n_acc !== 6) begin
            n_err++; $display("FAIL dma_we_stall: got low=%0d drops=%0d acc=%0d required 2 0 6",
                              n_low, drop_cnt, n_acc);
        end
        foreach (addrs[k]) begin
            dma_issue(addrs[k]);
            exp = exp_q.pop_front();
            n_cmp++;
            if (bus.dma_dat_o !== exp) begin
                n_err++; $display("FAIL stall_read[%0d]: got %h required %h", addrs[k], bus.dma_dat_o, exp);
            end
        end
    endtask

    task automatic test_release_order();
        bit acc;
        int n_acc = 0;
        logic [1:0] seen [4];
        rel = 1'b1; cycle(); rel = 1'b0;
        seen[0] = full;
        rel = 1'b1; cycle(); rel = 1'b0;
        seen[1] = full;
        for (int i = 0; i < 9; i++) begin
            push(64'h300 + 64'(i), acc);
            if (acc) n_acc++;
        end
        n_cmp++;
        if (seen[0] !== 2'b00 || seen[1] !== 2'b00 || full !== 2'b11 || n_acc !== 9) begin
            n_err++; $display("FAIL ignored_release: got %b %b then full=%b acc=%0d required 00 00 11 9",
                              seen[0], seen[1], full, n_acc);
        end
        rel = 1'b1; cycle(); rel = 1'b0;
        seen[2] = full;
        rel = 1'b1; cycle(); rel = 1'b0;
        seen[3] = full;
        n_cmp++;
        if (seen[2] !== 2'b10 || seen[3] !== 2'b00) begin
            n_err++; $display("FAIL release_order: got %b %b required 10 00", seen[2], seen[3]);
        end
    endtask

    task automatic test_collision();
        bit acc;
        logic [DW-1:0] exp;
        for (int i = 0; i < 5; i++) push(64'h200 + 64'(i), acc);
        bus.dma_en_i  = 1'b1;
        bus.dma_adr_i = AW'(5);
        exp_q.push_back(mem_m[5]);
        push(64'h2AA, acc);
        bus.dma_en_i  = 1'b0;
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.dma_dat_o !== exp || acc !== 1'b1) begin
            n_err++; $display("FAIL collision_old: got %h acc=%b required %h 1", bus.dma_dat_o, acc, exp);
        end
        dma_issue(5);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.dma_dat_o !== exp || exp !== 64'h2AA) begin
            n_err++; $display("FAIL collision_new: got %h required 2aa", bus.dma_dat_o);
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        logic [DW-1:0] exp;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 64'h777;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({half_done, half_idx, full, overrun, drop_cnt} !== 21'd0 || bus.dma_dat_o !== 64'd0) begin
            n_err++; $display("FAIL async_reset: got %b/%b/%b/%b/%h dat=%h required all zero",
                              half_done, half_idx, full, overrun, drop_cnt, bus.dma_dat_o);
        end
        bus.s_valid_i = 1'b0;
        cycle();
        rst_n = 1'b1;
        wp_m = 0;
        cycle();
        push(64'hABC, acc);
        dma_issue(0);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.dma_dat_o !== exp || exp !== 64'hABC) begin
            n_err++; $display("FAIL post_reset_addr0: got %h required abc", bus.dma_dat_o);
        end
    endtask

    task automatic test_saturation();
        bit acc;
        int n_acc = 0;
        for (int i = 0; i < 15; i++) begin
            push(64'h400 + 64'(i), acc);
            if (acc) n_acc++;
        end
        n_cmp++;
        if (n_acc !== 15 || full !== 2'b11) begin
            n_err++; $display("FAIL sat_fill: got acc=%0d full=%b required 15 11", n_acc, full);
        end
        bus.s_valid_i = 1'b1;
        repeat (65535) cycle();
        n_cmp++;
        if (drop_cnt !== 16'hFFFF || overrun !== 1'b1) begin
            n_err++; $display("FAIL sat_reach: got %h ovr=%b required ffff 1", drop_cnt, overrun);
        end
        cycle();
        n_cmp++;
        if (drop_cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL sat_hold: got %h required ffff", drop_cnt);
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        n_cmp++;
        if (drop_cnt !== 16'd0 || overrun !== 1'b0) begin
            n_err++; $display("FAIL clr_wins: got %h ovr=%b required 0 0", drop_cnt, overrun);
        end
        cycle();
        bus.s_valid_i = 1'b0;
        n_cmp++;
        if (drop_cnt !== 16'd1 || overrun !== 1'b1) begin
            n_err++; $display("FAIL restart_count: got %h ovr=%b required 1 1", drop_cnt, overrun);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_half();
        test_overrun();
        test_dma_write_stall();
        test_release_order();
        test_collision();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
